// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable generator: one prescaler counter producing a 1-cycle tick
// and a registered square clk_out, with start/stop, one-shot and deferred divisor reload.
module clk_div_ctrl #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 2,
    parameter int NT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             load,
    input  logic [CNT_W-1:0] div_val,
    input  logic [NT_W-1:0]  nticks,
    output logic             tick,
    output logic             clk_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] div_r, div_d;
    logic [NT_W-1:0]  nt_r, nt_d;
    logic [NT_W:0]    tick_left, tl_d;
    logic             pend, pend_d;
    logic [CNT_W-1:0] pend_div, pdiv_d;
    logic [NT_W-1:0]  pend_nt, pnt_d;
    logic             mode_r, mode_d;
    logic             tick_d, clk_out_d, busy_d, done_d;

    logic [CNT_W-1:0] eff_div;
    logic             terminal;
    logic [NT_W-1:0]  start_nt;

    assign eff_div   = (div_r == '0) ? CNT_W'(1) : div_r;
    assign terminal  = (cnt == eff_div - CNT_W'(1));
    // A load in the same cycle as start takes effect for that start.
    assign start_nt  = load ? nticks : nt_r;
    assign state_dbg = state;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        div_d     = div_r;
        nt_d      = nt_r;
        tl_d      = tick_left;
        pend_d    = pend;
        pdiv_d    = pend_div;
        pnt_d     = pend_nt;
        mode_d    = mode_r;
        tick_d    = 1'b0;
        clk_out_d = clk_out;
        done_d    = 1'b0;

        // Outside IDLE a load is held pending until a safe boundary.
        if (state != S_IDLE && load) begin
            pend_d = 1'b1;
            pdiv_d = div_val;
            pnt_d  = nticks;
        end

        case (state)
            S_IDLE: begin
                if (load) begin
                    div_d = div_val;
                    nt_d  = nticks;
                end
                if (start && !stop) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    mode_d  = mode;
                    tl_d    = (start_nt == '0) ? {1'b1, {NT_W{1'b0}}} : {1'b0, start_nt};
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    clk_out_d = 1'b0;
                    if (pend_d) begin
                        div_d  = pdiv_d;
                        nt_d   = pnt_d;
                        pend_d = 1'b0;
                    end
                end else if (terminal) begin
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    clk_out_d = ~clk_out;
                    if (pend_d) begin
                        div_d  = pdiv_d;
                        nt_d   = pnt_d;
                        pend_d = 1'b0;
                    end
                    if (mode_r) begin
                        tl_d = tick_left - (NT_W+1)'(1);
                        if (tick_left == (NT_W+1)'(1)) begin
                            state_d   = S_DONE;
                            clk_out_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (pend_d) begin
                    div_d  = pdiv_d;
                    nt_d   = pnt_d;
                    pend_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div_r     <= CNT_W'(DEF_DIV);
            nt_r      <= '0;
            tick_left <= '0;
            pend      <= 1'b0;
            pend_div  <= '0;
            pend_nt   <= '0;
            mode_r    <= 1'b0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            div_r     <= div_d;
            nt_r      <= nt_d;
            tick_left <= tl_d;
            pend      <= pend_d;
            pend_div  <= pdiv_d;
            pend_nt   <= pnt_d;
            mode_r    <= mode_d;
            tick      <= tick_d;
            clk_out   <= clk_out_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: inputs change and outputs are sampled 1 time unit
// after each rising edge, so a sample shows what that edge registered.
module tb_clk_div_ctrl;
    localparam int CNT_W = 16;
    localparam int NT_W  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             mode = 1'b0;
    logic             load = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic [NT_W-1:0]  nticks = '0;
    logic             tick, clk_out, busy, done;
    logic [1:0]       state_dbg;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(2), .NT_W(NT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .load(load), .div_val(div_val), .nticks(nticks),
        .tick(tick), .clk_out(clk_out), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        chk("rst_tick", tick, 0);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        reset = 1'b1;
        cyc();
        chk("idle_busy", busy, 0);

        // Continuous, divide by 4
        load = 1'b1; div_val = 4; cyc(); load = 1'b0;
        start = 1'b1; mode = 1'b0; cyc(); start = 1'b0;
        chk("a_busy_start", busy, 1);
        chk("a_tick_start", tick, 0);
        for (int k = 1; k <= 14; k++) begin
            cyc();
            chk("a_tick", tick, (k % 4 == 0) ? 1 : 0);
            chk("a_clk_out", clk_out, (k / 4) % 2);
            chk("a_busy", busy, 1);
            chk("a_done", done, 0);
        end
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("a_stop_busy", busy, 0);
        chk("a_stop_clk_out", clk_out, 0);
        chk("a_stop_tick", tick, 0);
        chk("a_stop_state", state_dbg, 0);

        // div_val=0 loaded together with start: tick every cycle
        load = 1'b1; div_val = 0; start = 1'b1; cyc(); load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("b0_tick", tick, 1);
            chk("b0_clk_out", clk_out, k % 2);
        end
        stop = 1'b1; cyc(); stop = 1'b0;

        // div_val=1: tick every cycle
        load = 1'b1; div_val = 1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("b1_tick", tick, 1);
            chk("b1_clk_out", clk_out, k % 2);
        end
        stop = 1'b1; cyc(); stop = 1'b0;

        // One-shot, div 3, 5 ticks
        load = 1'b1; div_val = 3; nticks = 5; cyc(); load = 1'b0;
        start = 1'b1; mode = 1'b1; cyc(); start = 1'b0; mode = 1'b0;
        n_ticks = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            n_ticks += int'(tick);
            chk("c_tick", tick, (k % 3 == 0) ? 1 : 0);
            chk("c_clk_out", clk_out, (k == 15) ? 0 : (k / 3) % 2);
            chk("c_busy", busy, (k < 15) ? 1 : 0);
            chk("c_done", done, 0);
        end
        cyc();
        chk("c_done_pulse", done, 1);
        chk("c_done_busy", busy, 0);
        chk("c_done_clk_out", clk_out, 0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            n_ticks += int'(tick);
            chk("c_done_after", done, 0);
        end
        chk("c_tick_count", n_ticks, 5);
        chk("c_final_state", state_dbg, 0);

        // One-shot with nticks=0 means 256 ticks
        load = 1'b1; div_val = 2; nticks = 0; cyc(); load = 1'b0;
        start = 1'b1; mode = 1'b1; cyc(); start = 1'b0; mode = 1'b0;
        n_ticks = 0; n_done = 0;
        for (int k = 1; k <= 600; k++) begin
            cyc();
            n_ticks += int'(tick);
            n_done  += int'(done);
        end
        chk("c256_tick_count", n_ticks, 256);
        chk("c256_done_count", n_done, 1);
        chk("c256_busy", busy, 0);

        // Continuous div 10, reload 7 then overwrite with 3 mid-period
        load = 1'b1; div_val = 10; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin
                load = 1'b1; div_val = 7;
            end else if (k == 6) begin
                load = 1'b1; div_val = 3;
            end else begin
                load = 1'b0;
            end
            cyc();
            chk("d_tick", tick, (k == 10 || k == 13 || k == 16 || k == 19) ? 1 : 0);
        end
        load = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;

        // Continuous div 5, stop on a terminal count
        load = 1'b1; div_val = 5; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            chk("e_tick", tick, (k == 5) ? 1 : 0);
            chk("e_clk_out", clk_out, (k >= 5) ? 1 : 0);
        end
        stop = 1'b1; cyc();
        chk("e_stop_tick", tick, 0);
        chk("e_stop_busy", busy, 0);
        chk("e_stop_clk_out", clk_out, 0);
        chk("e_stop_state", state_dbg, 0);
        start = 1'b1; cyc();
        chk("e_startstop_busy", busy, 0);
        chk("e_startstop_state", state_dbg, 0);
        cyc();
        chk("e_startstop_busy2", busy, 0);
        stop = 1'b0; cyc(); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("e_restart_tick", tick, (k == 5) ? 1 : 0);
        end
        stop = 1'b1; cyc(); stop = 1'b0;

        // One-shot interrupted by reset, with a pending load discarded
        load = 1'b1; div_val = 3; nticks = 5; cyc(); load = 1'b0;
        start = 1'b1; mode = 1'b1; cyc(); start = 1'b0; mode = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                load = 1'b1; div_val = 7;
            end
            cyc();
        end
        load = 1'b0;
        chk("f_pre_busy", busy, 1);
        chk("f_pre_clk_out", clk_out, 1);
        #2 reset = 1'b0;
        #1;
        chk("f_rst_tick", tick, 0);
        chk("f_rst_clk_out", clk_out, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_done", done, 0);
        chk("f_rst_state", state_dbg, 0);
        cyc(); cyc();
        reset = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("f_def_tick", tick, (k % 2 == 0) ? 1 : 0);
        end
        stop = 1'b1; cyc(); stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable, synchronous clock-enable generator and controller. It replaces hard-wired ripple dividers wherever a block needs a schedulable divided rate.
- It sequences a single prescaler counter with start/stop control, continuous or one-shot operation, and safe divisor reload.
- Outputs are a 1-cycle `tick` strobe and a registered square `clk_out` for downstream logic such as display scan, debouncers and timers. All logic runs in the `clk` domain; there is no ripple clocking.

Parameters:
- CNT_W, 16, width of divisor register and prescaler counter.
- DEF_DIV, 2, divisor value loaded at reset.
- NT_W, 8, width of one-shot tick-count register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level sampled each clk; begins operation when IDLE.
- stop  input  1  level sampled each clk; aborts RUN and returns to IDLE.
- mode  input  1  sampled with start: 0 = continuous, 1 = one-shot.
- load  input  1  1-cycle request to take div_val/nticks.
- div_val  input  CNT_W  new divisor; 0 and 1 both mean "tick every cycle".
- nticks  input  NT_W  one-shot tick count; 0 means 2^NT_W.
- tick  output  1  1-cycle strobe once per divisor period.
- clk_out  output  1  toggles on every tick (period = 2*div cycles).
- busy  output  1  high in RUN.
- done  output  1  1-cycle pulse when a one-shot completes.

Behaviour:
- Async reset (reset=0):
  - state=IDLE, cnt=0, div_r=DEF_DIV, nt_r=0, tick_left=0, pend=0, mode_r=0.
  - All outputs 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - load=1: div_r<=div_val and nt_r<=nticks, effective next cycle.
  - start=1 and stop=0: go to RUN, cnt<=0, mode_r<=mode, tick_left<=nt_r (0 maps to 2^NT_W).
  - If load and start are asserted in the same cycle, start uses the newly loaded values.
- RUN:
  - Counter: cnt increments each cycle.
  - Terminal count: when cnt==eff_div-1, where eff_div=max(div_r,1):
    - cnt<=0;
    - tick<=1 next cycle;
    - clk_out<=~clk_out.
  - First tick: the first tick is high exactly eff_div cycles after the edge that sampled start. Ticks then repeat every eff_div cycles.
  - Load in RUN: load latches div_val/nticks into a pending register and sets pend=1. A later load overwrites the pending value.
    - pend is applied (div_r/nt_r updated, pend cleared) at the terminal-count edge.
    - The current period always completes with the old divisor.
    - The new divisor governs the following period.
    - In one-shot mode, tick_left is not reloaded mid-run.
  - One-shot (mode_r=1): tick_left decrements on each terminal count. When the terminal count hits with tick_left==1:
    - the final tick is emitted;
    - next state is DONE;
    - clk_out<=0.
  - Continuous (mode_r=0): runs until stop.
  - start while in RUN is ignored.
- DONE:
  - done=1 for exactly one cycle.
  - busy=0.
  - Next state is IDLE unconditionally.
  - A pending load is applied on entry to IDLE.
- stop:
  - In RUN, stop=1 causes next state IDLE, cnt<=0, clk_out<=0, tick<=0 and no done.
  - stop has priority over start, and over a terminal count in the same cycle: that tick is suppressed, and a one-shot neither completes nor pulses done.
  - In IDLE/DONE, stop has no effect, except that it blocks start.
- busy=1 iff state==RUN, registered with the state.
- Reset mid-operation: immediate return to reset values. Pending load is discarded.
- Wrap-around: cnt never exceeds eff_div-1. tick_left is NT_W+1 bits so that 2^NT_W is representable.

Test Plan:
- Reset; continuous, div_val=4, load, then start.
  - tick at cycles 4, 8, 12, ... after start.
  - clk_out toggles at each tick (period 8).
  - busy=1, done never asserts.
- div_val=0 (and separately div_val=1), continuous start.
  - tick high every cycle.
  - clk_out toggles every cycle.
- One-shot, div_val=3, nticks=5.
  - Exactly 5 ticks, 3 cycles apart.
  - done pulses 1 cycle after the 5th tick edge.
  - busy then 0 and clk_out=0.
  - Repeat with nticks=0: exactly 256 ticks.
- Continuous div=10; in cycle 4 of a period, load div_val=3.
  - Current tick still arrives at cycle 10.
  - Next ticks are at +3, +6, ...
  - A second load before that boundary replaces the pending value.
- Continuous div=5; assert stop in the same cycle as a terminal count.
  - No tick is emitted.
  - Next cycle is IDLE with busy=0, clk_out=0, cnt=0.
  - start and stop together in IDLE: remains IDLE.
- Running one-shot; drop reset mid-period.
  - All outputs go to 0 immediately.
  - After release, div_r=DEF_DIV; start yields a tick every 2 cycles.
